// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and output-stage state encoding for the fetch unit
package instruction_fetch_pkg;

  // Prefetch buffer depth; fixed at two entries in this release.
  localparam int FETCH_FIFO_DEPTH = 2;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_INCR = 32'd4;

  // Output stage: VALID presents a word, RELEASE waits for the acknowledge to drop.
  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_VALID   = 2'd1,
    OUT_RELEASE = 2'd2
  } out_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small prefetch buffer with flush, holding fetched instruction words
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy update; flush empties the buffer like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - prefetching instruction fetch unit with four-phase decoder handshake
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        DOR,
  input  logic        ack_from_next,
  output logic [31:0] data_out
);

  localparam int            CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(FIFO_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  out_state_e  state_q, state_d;
  logic        dor_q, dor_d;
  logic [31:0] data_out_q, data_out_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic [CW:0]   occupancy;

  // Words buffered plus the one possibly on its way back from memory.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

  // A read is only issued when its response is certain to find a free slot.
  assign mem_rd   = !reset && !halt && !redirect && !fifo_full && (occupancy < OCC_LIMIT);
  assign mem_addr = pc_q;

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign fifo_push = inflight_q && !redirect;
  // Stale buffered words must not reach the output while the buffer is being flushed.
  assign fifo_pop  = (state_q == OUT_IDLE) && !fifo_empty && !redirect;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Next fetch address and in-flight flag; redirect wins over sequential advance.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = mem_rd;
    if (redirect) begin
      pc_d = redirect_target;
    end else if (mem_rd) begin
      pc_d = pc_q + PC_INCR;
    end
  end

  // Fetch-side state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Output handshake: present a word, wait for ack, then wait for ack to drop.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    case (state_q)
      OUT_IDLE: begin
        if (fifo_pop) begin
          state_d    = OUT_VALID;
          data_out_d = fifo_head;
        end
      end
      OUT_VALID: begin
        if (ack_from_next) state_d = OUT_RELEASE;
      end
      OUT_RELEASE: begin
        if (!ack_from_next) state_d = OUT_IDLE;
      end
      default: state_d = OUT_IDLE;
    endcase
    dor_d = (state_d == OUT_VALID);
  end

  // Output-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OUT_IDLE;
      dor_q      <= 1'b0;
      data_out_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      dor_q      <= dor_d;
      data_out_q <= data_out_d;
    end
  end

  assign DOR      = dor_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = 32'hDEAD_BEEF;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic        DOR;
  logic        ack_from_next;
  logic [31:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] issued_q [$];
  logic        rd_pend   = 1'b0;
  logic [31:0] addr_pend = 32'h0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .DOR             (DOR),
    .ack_from_next   (ack_from_next),
    .data_out        (data_out)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  // Memory: word at address a is a/4+1, returned during the cycle after the read cycle.
  always @(negedge clk) begin
    mem_data  = rd_pend ? word_at(addr_pend) : 32'hDEAD_BEEF;
    rd_pend   = mem_rd;
    addr_pend = mem_addr;
    if (mem_rd) issued_q.push_back(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dor(input string tag);
    int n;
    n = 0;
    while (DOR !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (DOR !== 1'b1) begin
      n_err++;
      $display("FAIL %s dor_timeout: DOR=%b required 1", tag, DOR);
    end
  endtask

  task automatic consume(input logic [31:0] exp, input string tag);
    wait_dor(tag);
    n_vec++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL %s data: got %h required %h", tag, data_out, exp);
    end
    tick();
    tick();
    n_vec++;
    if (DOR !== 1'b1 || data_out !== exp) begin
      n_err++;
      $display("FAIL %s hold: DOR=%b data=%h required 1/%h", tag, DOR, data_out, exp);
    end
    ack_from_next = 1'b1;
    tick();
    n_vec++;
    if (DOR !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: DOR=%b required 0", tag, DOR);
    end
    ack_from_next = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; ack_from_next = 1'b0;
    tick();
    tick();
    n_vec++;
    if (mem_rd !== 1'b0 || DOR !== 1'b0 || data_out !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: rd=%b dor=%b data=%h addr=%h required 0/0/0/0",
               mem_rd, DOR, data_out, mem_addr);
    end
  endtask

  task automatic test_latency();
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_read: rd=%b addr=%h required 1/0", mem_rd, mem_addr);
    end
    tick();
    n_vec++;
    if (DOR !== 1'b0) begin n_err++; $display("FAIL latency_e1: DOR=%b required 0", DOR); end
    tick();
    n_vec++;
    if (DOR !== 1'b0) begin n_err++; $display("FAIL latency_e2: DOR=%b required 0", DOR); end
    tick();
    n_vec++;
    if (DOR !== 1'b1 || data_out !== 32'd1) begin
      n_err++;
      $display("FAIL latency_e3: DOR=%b data=%h required 1/1", DOR, data_out);
    end
  endtask

  task automatic test_sequence();
    for (int i = 1; i <= 4; i++) consume(32'(i), "seq");
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (issued_q.size() <= i || issued_q[i] !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL seq_addr[%0d]: got %h required %h", i,
                 (issued_q.size() > i) ? issued_q[i] : 32'hFFFF_FFFF, 32'(4 * i));
      end
    end
  endtask

  task automatic test_held_ack();
    int highs;
    highs = 0;
    wait_dor("held");
    n_vec++;
    if (data_out !== 32'd5) begin n_err++; $display("FAIL held_word: got %h required 5", data_out); end
    ack_from_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (DOR !== 1'b0) highs++;
    end
    n_vec++;
    if (highs !== 0) begin n_err++; $display("FAIL held_dor: %0d high cycles required 0", highs); end
    ack_from_next = 1'b0;
    tick();
    wait_dor("held_next");
    n_vec++;
    if (data_out !== 32'd6) begin n_err++; $display("FAIL held_next: got %h required 6", data_out); end
  endtask

  task automatic test_stall();
    int rds;
    rds = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 4 && mem_rd !== 1'b0) rds++;
    end
    n_vec++;
    if (rds !== 0 || mem_rd !== 1'b0 || mem_addr !== 32'd32) begin
      n_err++;
      $display("FAIL stall_fetch: rds=%0d rd=%b addr=%h required 0/0/00000020", rds, mem_rd, mem_addr);
    end
    n_vec++;
    if (issued_q.size() !== 8) begin
      n_err++;
      $display("FAIL stall_issued: got %0d reads required 8", issued_q.size());
    end
    n_vec++;
    if (DOR !== 1'b1 || data_out !== 32'd6) begin
      n_err++;
      $display("FAIL stall_out: DOR=%b data=%h required 1/6", DOR, data_out);
    end
  endtask

  task automatic test_redirect();
    redirect_target = 32'h100;
    redirect = 1'b1;
    #1;
    n_vec++;
    if (mem_rd !== 1'b0) begin n_err++; $display("FAIL redir_rd: rd=%b required 0", mem_rd); end
    tick();
    redirect = 1'b0;
    redirect_target = 32'h0;
    #1;
    n_vec++;
    if (DOR !== 1'b1 || data_out !== 32'd6) begin
      n_err++;
      $display("FAIL redir_keep: DOR=%b data=%h required 1/6", DOR, data_out);
    end
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redir_pc: rd=%b addr=%h required 1/00000100", mem_rd, mem_addr);
    end
    ack_from_next = 1'b1;
    tick();
    ack_from_next = 1'b0;
    tick();
    consume(32'd65, "redir_first");
    wait_dor("redir_second");
    n_vec++;
    if (data_out !== 32'd66) begin n_err++; $display("FAIL redir_second: got %h required 42", data_out); end
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if (mem_addr !== 32'h110 || mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL redir_full: addr=%h rd=%b required 00000110/0", mem_addr, mem_rd);
    end
  endtask

  task automatic test_halt();
    logic [31:0] got [$];
    logic        prev;
    int          rds;
    rds  = 0;
    prev = 1'b1;
    halt = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      ack_from_next = DOR;
      if (mem_rd !== 1'b0) rds++;
      tick();
      if (DOR === 1'b1 && prev !== 1'b1) got.push_back(data_out);
      prev = DOR;
    end
    n_vec++;
    if (rds !== 0) begin n_err++; $display("FAIL halt_rd: %0d reads required 0", rds); end
    n_vec++;
    if (got.size() !== 2 || got[0] !== 32'd67 || got[1] !== 32'd68) begin
      n_err++;
      $display("FAIL halt_drain: %0d words first=%h required 2 words 43,44",
               got.size(), (got.size() > 0) ? got[0] : 32'hFFFF_FFFF);
    end
    n_vec++;
    if (DOR !== 1'b0) begin n_err++; $display("FAIL halt_empty: DOR=%b required 0", DOR); end
    halt = 1'b0;
    ack_from_next = 1'b0;
    #1;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h110) begin
      n_err++;
      $display("FAIL halt_resume: rd=%b addr=%h required 1/00000110", mem_rd, mem_addr);
    end
  endtask

  task automatic test_redirect_inflight_wrap();
    int bad;
    bad = 0;
    tick();
    redirect_target = 32'hFFFF_FFFC;
    redirect = 1'b1;
    halt = 1'b1;
    #1;
    n_vec++;
    if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rh_rd: rd=%b required 0", mem_rd); end
    tick();
    redirect = 1'b0;
    #1;
    n_vec++;
    if (mem_addr !== 32'hFFFF_FFFC || mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL rh_pc: addr=%h rd=%b required fffffffc/0", mem_addr, mem_rd);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (DOR !== 1'b0 || mem_rd !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL rh_discard: %0d active cycles required 0", bad); end
    halt = 1'b0;
    #1;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_issue: rd=%b addr=%h required 1/fffffffc", mem_rd, mem_addr);
    end
    tick();
    n_vec++;
    if (mem_addr !== 32'h0 || mem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_pc: addr=%h rd=%b required 00000000/1", mem_addr, mem_rd);
    end
    consume(32'h4000_0000, "wrap_top");
    consume(32'd1, "wrap_zero");
  endtask

  task automatic test_reset_mid_handshake();
    int n;
    n = 0;
    while (!(mem_rd === 1'b1 && DOR === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (mem_rd !== 1'b1 || DOR !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: rd=%b DOR=%b required 1/1", mem_rd, DOR);
    end
    tick();
    reset = 1'b1;
    #1;
    n_vec++;
    if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: rd=%b required 0", mem_rd); end
    tick();
    n_vec++;
    if (DOR !== 1'b0 || data_out !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid: DOR=%b data=%h addr=%h required 0/0/0", DOR, data_out, mem_addr);
    end
    reset = 1'b0;
    #1;
    tick();
    tick();
    n_vec++;
    if (DOR !== 1'b0) begin n_err++; $display("FAIL rst_discard: DOR=%b required 0", DOR); end
    tick();
    n_vec++;
    if (DOR !== 1'b1 || data_out !== 32'd1) begin
      n_err++;
      $display("FAIL rst_restart: DOR=%b data=%h required 1/1", DOR, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sequence();
    test_held_ack();
    test_stall();
    test_redirect();
    test_halt();
    test_redirect_inflight_wrap();
    test_reset_mid_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
